mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Multi-cycle unsigned 8x8 multiply / 8÷8 divide unit that sits directly downstream of the 16x8 register file read ports.
- Consumes readData1 and readData2 as operands and computes the result iteratively.
- Feeds the result back to the register file write port as two sequential 8-bit writes: low/quotient to rd, high/remainder to rd+1.
- The CPU control stalls on busy.

Parameters:
- WIDTH, 8, operand/register data width.
- ADDR_W, 4, register address width (16 registers).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; accepted only in IDLE.
- op  input  1  0 = multiply, 1 = divide.
- opA  input  WIDTH  operand A (multiplicand / dividend), from readData1.
- opB  input  WIDTH  operand B (multiplier / divisor), from readData2.
- rd  input  ADDR_W  destination base register.
- busy  output  1  high from acceptance until the operation completes.
- done  output  1  one-cycle pulse in the final write-back cycle.
- dbz  output  1  divide-by-zero flag for the last operation; held until the next acceptance.
- wbEn  output  1  register file write enable.
- wbAdr  output  ADDR_W  register file write address.
- wbData  output  WIDTH  register file write data.

Behaviour:
- Reset (asynchronous, any state): state = IDLE.
  - busy, done, dbz, wbEn = 0; wbAdr, wbData = 0.
  - Internal accumulators and counter = 0.
  - An operation in flight is abandoned with no further writes.
- States: IDLE, CALC, WB_LO, WB_HI.
- IDLE: start=1 at edge E0 →
  - latch op, opA, opB, rd;
  - clear dbz, then set it if op=1 and opB=0;
  - counter = WIDTH-1;
  - go to CALC.
  - Operand changes after E0 are ignored.
- CALC: one iteration per edge (E1..E_WIDTH).
  - Counter decrements; at count 0 the step executes and the state goes to WB_LO.
  - Latency is fixed regardless of operand values or dbz.
- Multiply: shift-add, 2*WIDTH-bit product.
  - lo = product[WIDTH-1:0], hi = product[2*WIDTH-1:WIDTH].
- Divide: restoring division, one quotient bit per iteration, MSB first.
  - lo = quotient, hi = remainder.
- Divide by zero: lo = all ones (0xFF), hi = opA; dbz = 1.
- WB_LO (one cycle): wbEn=1, wbAdr=rd, wbData=lo.
- WB_HI (one cycle): wbEn=1, wbAdr=(rd+1) mod 2^ADDR_W (wraps 15→0), wbData=hi, done=1.
  - Next state is IDLE.
- wbEn, wbAdr, wbData and done are registered state outputs, combinational only from the state register. wbEn=0 in IDLE and CALC.
- busy = 1 in CALC, WB_LO and WB_HI. Total occupancy is WIDTH+2 cycles (10 at default).
- start while busy is ignored; no queueing.
- start in the same cycle that WB_HI completes is ignored; it is accepted on the first edge seen in IDLE.
- rd = 0: writes to r0 are still issued. Register-0 semantics are the register file's concern.
- rd = 15: the low/quotient write goes to r15 and the high/remainder write goes to r0.

Test Plan:
- Reset, then mul opA=0xFF opB=0xFF rd=3:
  - busy for 10 cycles;
  - WB_LO writes r3=0x01; WB_HI writes r4=0xFE with done=1;
  - dbz=0.
- Div opA=200 (0xC8) opB=7 rd=5:
  - r5=0x1C (28), r6=0x04;
  - exactly two wbEn cycles, 9 and 10 cycles after acceptance.
- Div opA=0x2A opB=0 rd=1:
  - r1=0xFF, r2=0x2A, dbz=1;
  - dbz stays 1 after done until the next accepted start, then clears.
- Mul opA=0x10 opB=0x20 rd=15:
  - r15=0x00, r0=0x02 (address wrap).
- Robustness:
  - change opA/opB and pulse start during CALC → result unchanged and no second operation;
  - assert rst during CALC → busy=0, wbEn=0 immediately, no writes, next start runs normally.
- Back-to-back:
  - hold start=1 continuously → operations start every WIDTH+3 cycles;
  - each produces exactly one WB_LO/WB_HI pair.

Source files
------------

// File: rtl/mul_div_if.sv
// Bundles the request/response signals of the multiply/divide unit.
//
// Signals:
//   start, op, opA, opB, rd : request side, driven by CPU control / register file reads
//   busy, done, dbz         : status back to CPU control
//   wbEn, wbAdr, wbData     : register file write port
//
// Modports:
//   master : requester (drives the request, observes status and write-back)
//   slave  : the mul_div_unit itself
interface mul_div_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic              start;
    logic              op;
    logic [WIDTH-1:0]  opA;
    logic [WIDTH-1:0]  opB;
    logic [ADDR_W-1:0] rd;
    logic              busy;
    logic              done;
    logic              dbz;
    logic              wbEn;
    logic [ADDR_W-1:0] wbAdr;
    logic [WIDTH-1:0]  wbData;

    modport master (
        output start, op, opA, opB, rd,
        input  busy, done, dbz, wbEn, wbAdr, wbData
    );

    modport slave (
        input  start, op, opA, opB, rd,
        output busy, done, dbz, wbEn, wbAdr, wbData
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle unsigned WIDTH x WIDTH multiply / WIDTH / WIDTH divide unit.
// Operands are latched on acceptance, one iteration runs per clock in CALC,
// then the result is written back as two register file writes:
// low/quotient to rd, high/remainder to rd+1 (address wraps).
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active-high
//   mdu_s    : mul_div_if slave modport
//     start/op/opA/opB/rd in; busy/done/dbz/wbEn/wbAdr/wbData out
module mul_div_unit #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic     clk,
    input  logic     rst,
    mul_div_if.slave mdu_s
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WB_LO = 2'd2,
        WB_HI = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;   // {hi, lo}: product, or {remainder, quotient}
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic                op_q, op_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic                dbz_q, dbz_d;

    // Shift-add multiply step, multiplier consumed MSB first.
    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [2*WIDTH-1:0] acc,
        input logic [WIDTH-1:0]   a,
        input logic               b_bit
    );
        logic [2*WIDTH-1:0] addend;
        addend = b_bit ? {{WIDTH{1'b0}}, a} : '0;
        return {acc[2*WIDTH-2:0], 1'b0} + addend;
    endfunction

    // Restoring divide step: shift the next dividend bit into the partial
    // remainder, subtract the divisor when it fits. With a zero divisor every
    // step "fits", so the quotient saturates to all ones and the remainder
    // collects the whole dividend -- exactly the divide-by-zero result.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [2*WIDTH-1:0] acc,
        input logic               a_bit,
        input logic [WIDTH-1:0]   b
    );
        logic [WIDTH:0] trial;
        logic           q_bit;
        trial = {acc[2*WIDTH-1:WIDTH], a_bit};
        if (trial >= {1'b0, b}) begin
            trial = trial - {1'b0, b};
            q_bit = 1'b1;
        end else begin
            q_bit = 1'b0;
        end
        return {trial[WIDTH-1:0], acc[WIDTH-2:0], q_bit};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            rd_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        rd_d    = rd_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (mdu_s.start) begin
                    a_d     = mdu_s.opA;
                    b_d     = mdu_s.opB;
                    op_d    = mdu_s.op;
                    rd_d    = mdu_s.rd;
                    dbz_d   = mdu_s.op && (mdu_s.opB == '0);
                    acc_d   = '0;
                    cnt_d   = CNT_INIT;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = op_q ? div_step(acc_q, a_q[cnt_q], b_q)
                             : mul_step(acc_q, a_q, b_q[cnt_q]);
                if (cnt_q == '0) begin
                    state_d = WB_LO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WB_LO: state_d = WB_HI;
            WB_HI: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the state register only; nothing combinational from inputs.
    always_comb begin
        mdu_s.busy   = (state_q != IDLE);
        mdu_s.done   = 1'b0;
        mdu_s.dbz    = dbz_q;
        mdu_s.wbEn   = 1'b0;
        mdu_s.wbAdr  = '0;
        mdu_s.wbData = '0;
        if (state_q == WB_LO) begin
            mdu_s.wbEn   = 1'b1;
            mdu_s.wbAdr  = rd_q;
            mdu_s.wbData = acc_q[WIDTH-1:0];
        end else if (state_q == WB_HI) begin
            mdu_s.wbEn   = 1'b1;
            mdu_s.wbAdr  = rd_q + ADR_ONE;
            mdu_s.wbData = acc_q[2*WIDTH-1:WIDTH];
            mdu_s.done   = 1'b1;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit.
module tb_mul_div_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mul_div_if #(.WIDTH(8), .ADDR_W(4)) bus ();

    mul_div_unit #(.WIDTH(8), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .mdu_s (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture results (cycle k = k-th cycle after the accepting edge)
    int         cap_busy;
    int         cap_nwr;
    int         cap_lo_cyc;
    logic [3:0] cap_lo_adr;
    logic [7:0] cap_lo_dat;
    int         cap_hi_cyc;
    logic [3:0] cap_hi_adr;
    logic [7:0] cap_hi_dat;
    int         cap_done_cnt;
    int         cap_done_cyc;
    logic       cap_last_busy;

    task automatic issue(input logic op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] rd);
        @(negedge clk);
        bus.op    = op;
        bus.opA   = a;
        bus.opB   = b;
        bus.rd    = rd;
        bus.start = 1'b1;
        @(posedge clk);
    endtask

    task automatic capture(input int ncyc, input bit disturb);
        cap_busy = 0; cap_nwr = 0; cap_done_cnt = 0; cap_done_cyc = -1;
        cap_lo_cyc = -1; cap_hi_cyc = -1;
        cap_lo_adr = 'x; cap_lo_dat = 'x; cap_hi_adr = 'x; cap_hi_dat = 'x;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (disturb && k == 3) begin
                bus.opA   = 8'h55;
                bus.opB   = 8'h00;
                bus.op    = ~bus.op;
                bus.start = 1'b1;
            end
            if (disturb && k == 4) bus.start = 1'b0;
            if (bus.busy) cap_busy++;
            if (bus.wbEn) begin
                cap_nwr++;
                if (cap_nwr == 1) begin
                    cap_lo_cyc = k; cap_lo_adr = bus.wbAdr; cap_lo_dat = bus.wbData;
                end else if (cap_nwr == 2) begin
                    cap_hi_cyc = k; cap_hi_adr = bus.wbAdr; cap_hi_dat = bus.wbData;
                end
            end
            if (bus.done) begin
                cap_done_cnt++;
                cap_done_cyc = k;
            end
        end
        cap_last_busy = bus.busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", bus.dbz); end
        checks++; if (bus.wbEn !== 1'b0) begin errors++; $display("FAIL reset_wbEn: got %b expected 0", bus.wbEn); end
        checks++; if (bus.wbAdr !== 4'h0) begin errors++; $display("FAIL reset_wbAdr: got %h expected 0", bus.wbAdr); end
        checks++; if (bus.wbData !== 8'h00) begin errors++; $display("FAIL reset_wbData: got %h expected 00", bus.wbData); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul_max();
        issue(1'b0, 8'hFF, 8'hFF, 4'd3);
        capture(13, 1'b0);
        checks++; if (cap_busy !== 10) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 10", cap_busy); end
        checks++; if (cap_nwr !== 2) begin errors++; $display("FAIL mul_writes: got %0d expected 2", cap_nwr); end
        checks++; if (cap_lo_adr !== 4'd3 || cap_lo_dat !== 8'h01) begin errors++; $display("FAIL mul_lo: got r%0d=%h expected r3=01", cap_lo_adr, cap_lo_dat); end
        checks++; if (cap_hi_adr !== 4'd4 || cap_hi_dat !== 8'hFE) begin errors++; $display("FAIL mul_hi: got r%0d=%h expected r4=FE", cap_hi_adr, cap_hi_dat); end
        checks++; if (cap_done_cnt !== 1 || cap_done_cyc !== 10) begin errors++; $display("FAIL mul_done: got count %0d at cycle %0d expected 1 at 10", cap_done_cnt, cap_done_cyc); end
        checks++; if (bus.dbz !== 1'b0) begin errors++; $display("FAIL mul_dbz: got %b expected 0", bus.dbz); end
        checks++; if (cap_last_busy !== 1'b0) begin errors++; $display("FAIL mul_idle_after: got busy %b expected 0", cap_last_busy); end
    endtask

    task automatic test_div();
        issue(1'b1, 8'd200, 8'd7, 4'd5);
        capture(13, 1'b0);
        checks++; if (cap_nwr !== 2) begin errors++; $display("FAIL div_writes: got %0d expected 2", cap_nwr); end
        checks++; if (cap_lo_cyc !== 9 || cap_hi_cyc !== 10) begin errors++; $display("FAIL div_wb_timing: got %0d,%0d expected 9,10", cap_lo_cyc, cap_hi_cyc); end
        checks++; if (cap_lo_adr !== 4'd5 || cap_lo_dat !== 8'h1C) begin errors++; $display("FAIL div_quot: got r%0d=%h expected r5=1C", cap_lo_adr, cap_lo_dat); end
        checks++; if (cap_hi_adr !== 4'd6 || cap_hi_dat !== 8'h04) begin errors++; $display("FAIL div_rem: got r%0d=%h expected r6=04", cap_hi_adr, cap_hi_dat); end
        checks++; if (bus.dbz !== 1'b0) begin errors++; $display("FAIL div_dbz: got %b expected 0", bus.dbz); end
    endtask

    task automatic test_div_zero();
        issue(1'b1, 8'h2A, 8'h00, 4'd1);
        capture(13, 1'b0);
        checks++; if (cap_busy !== 10) begin errors++; $display("FAIL dbz_busy_cycles: got %0d expected 10", cap_busy); end
        checks++; if (cap_lo_adr !== 4'd1 || cap_lo_dat !== 8'hFF) begin errors++; $display("FAIL dbz_lo: got r%0d=%h expected r1=FF", cap_lo_adr, cap_lo_dat); end
        checks++; if (cap_hi_adr !== 4'd2 || cap_hi_dat !== 8'h2A) begin errors++; $display("FAIL dbz_hi: got r%0d=%h expected r2=2A", cap_hi_adr, cap_hi_dat); end
        checks++; if (bus.dbz !== 1'b1) begin errors++; $display("FAIL dbz_held: got %b expected 1", bus.dbz); end
        // Next accepted op clears the flag
        issue(1'b0, 8'h03, 8'h05, 4'd7);
        #1;
        checks++; if (bus.dbz !== 1'b0) begin errors++; $display("FAIL dbz_clear: got %b expected 0", bus.dbz); end
        capture(13, 1'b0);
        checks++; if (cap_lo_adr !== 4'd7 || cap_lo_dat !== 8'h0F || cap_hi_dat !== 8'h00) begin errors++; $display("FAIL dbz_next_op: got r%0d=%h hi=%h expected r7=0F hi=00", cap_lo_adr, cap_lo_dat, cap_hi_dat); end
    endtask

    task automatic test_addr_wrap();
        issue(1'b0, 8'h10, 8'h20, 4'd15);
        capture(13, 1'b0);
        checks++; if (cap_lo_adr !== 4'd15 || cap_lo_dat !== 8'h00) begin errors++; $display("FAIL wrap_lo: got r%0d=%h expected r15=00", cap_lo_adr, cap_lo_dat); end
        checks++; if (cap_hi_adr !== 4'd0 || cap_hi_dat !== 8'h02) begin errors++; $display("FAIL wrap_hi: got r%0d=%h expected r0=02", cap_hi_adr, cap_hi_dat); end
        // rd=0 still writes r0 then r1
        issue(1'b0, 8'h0C, 8'h0B, 4'd0);
        capture(13, 1'b0);
        checks++; if (cap_lo_adr !== 4'd0 || cap_lo_dat !== 8'h84 || cap_hi_adr !== 4'd1 || cap_hi_dat !== 8'h00) begin errors++; $display("FAIL rd0: got r%0d=%h r%0d=%h expected r0=84 r1=00", cap_lo_adr, cap_lo_dat, cap_hi_adr, cap_hi_dat); end
    endtask

    task automatic test_ignore_busy();
        issue(1'b1, 8'd200, 8'd7, 4'd5);
        capture(14, 1'b1);
        checks++; if (cap_nwr !== 2 || cap_busy !== 10) begin errors++; $display("FAIL busy_ignore_count: got %0d writes %0d busy expected 2 and 10", cap_nwr, cap_busy); end
        checks++; if (cap_lo_dat !== 8'h1C || cap_hi_dat !== 8'h04) begin errors++; $display("FAIL busy_ignore_result: got %h,%h expected 1C,04", cap_lo_dat, cap_hi_dat); end
    endtask

    task automatic test_reset_mid();
        int wr;
        issue(1'b0, 8'hFF, 8'h02, 4'd9);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.wbEn !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got busy=%b wbEn=%b expected 0,0", bus.busy, bus.wbEn); end
        @(negedge clk);
        rst = 1'b0;
        wr = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.wbEn || bus.busy) wr++;
        end
        checks++; if (wr !== 0) begin errors++; $display("FAIL midreset_no_writes: got %0d active cycles expected 0", wr); end
        issue(1'b0, 8'h07, 8'h09, 4'd2);
        capture(13, 1'b0);
        checks++; if (cap_lo_adr !== 4'd2 || cap_lo_dat !== 8'h3F || cap_hi_adr !== 4'd3 || cap_hi_dat !== 8'h00) begin errors++; $display("FAIL midreset_next_op: got r%0d=%h r%0d=%h expected r2=3F r3=00", cap_lo_adr, cap_lo_dat, cap_hi_adr, cap_hi_dat); end
    endtask

    task automatic test_back_to_back();
        int lo_n, hi_n, done_n;
        int lo_pos[$];
        lo_n = 0; hi_n = 0; done_n = 0;
        @(negedge clk);
        bus.op = 1'b0; bus.opA = 8'h03; bus.opB = 8'h07; bus.rd = 4'd8;
        bus.start = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (bus.wbEn && bus.wbAdr == 4'd8 && bus.wbData == 8'h15) begin lo_n++; lo_pos.push_back(k); end
            if (bus.wbEn && bus.wbAdr == 4'd9 && bus.wbData == 8'h00) hi_n++;
            if (bus.done) done_n++;
            if (k == 33) begin
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_idle: got busy %b expected 0", bus.busy); end
                bus.start = 1'b0;
            end
        end
        checks++; if (lo_n !== 3 || hi_n !== 3 || done_n !== 3) begin errors++; $display("FAIL b2b_pairs: got lo=%0d hi=%0d done=%0d expected 3 each", lo_n, hi_n, done_n); end
        checks++; if (lo_pos.size() != 3 || lo_pos[0] !== 9 || lo_pos[1] !== 20 || lo_pos[2] !== 31) begin errors++; $display("FAIL b2b_period: got %0d lo writes, first at %0d expected cycles 9,20,31", lo_pos.size(), (lo_pos.size() > 0) ? lo_pos[0] : -1); end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 1'b0;
        bus.opA = '0;
        bus.opB = '0;
        bus.rd = '0;
        test_reset();
        test_mul_max();
        test_div();
        test_div_zero();
        test_addr_wrap();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
